// File: rtl/instruction_fetch_unit.sv
// LEGv8 IF stage: PC ownership, single-outstanding imem fetch, IF/ID register and redirect/stall handling.
// Optional alignment trap on redirect targets is enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  PC_STEP  = 4
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirectTarget,
    output logic                imemReq,
    output logic [PC_WIDTH-1:0] imemAddr,
    input  logic                imemReady,
    input  logic                imemValid,
    input  logic [31:0]         imemData,
    output logic                instrValid,
    output logic [31:0]         instruction,
    output logic [10:0]         opcode,
    output logic [PC_WIDTH-1:0] pcOut
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                fetchFault
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic                squash;
    logic [31:0]         buf_word;
    logic [PC_WIDTH-1:0] buf_pc;

    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_seq;
    logic                slot_free;
    logic                take_redirect;

`ifdef FETCH_ALIGN_CHECK_EN
    logic bad_target;
    assign target     = redirectTarget;
    assign bad_target = |redirectTarget[1:0];
`else
    // Without the trap, misaligned targets are silently rounded down to a word boundary.
    logic unused_target_bits;
    assign target             = {redirectTarget[PC_WIDTH-1:2], 2'b00};
    assign unused_target_bits = ^redirectTarget[1:0];
`endif

    assign pc_seq        = pc + PC_WIDTH'(PC_STEP);
    assign slot_free     = !instrValid || !stall;
    assign take_redirect = redirect && (state != S_HALT);

    // The request must drop combinationally in a redirect cycle, so it cannot be registered.
    assign imemReq  = (state == S_REQ) && slot_free && !redirect;
    assign imemAddr = pc;
    assign opcode   = instruction[31:21];

    // NOTE: buffer and IF/ID data are plain registers, so resetting them is cheap and keeps outputs defined.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            instrValid  <= 1'b0;
            instruction <= '0;
            pcOut       <= '0;
            buf_word    <= '0;
            buf_pc      <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetchFault  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments let later statements override earlier ones without ordering races.
            if (!stall) begin
                instrValid <= 1'b0;
            end

            case (state)
                S_IDLE: state <= S_REQ;

                S_REQ: begin
                    if (imemReq && imemReady) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imemValid) begin
                        if (squash || redirect) begin
                            squash <= 1'b0;
                            state  <= S_REQ;
                        end else if (slot_free) begin
                            instrValid  <= 1'b1;
                            instruction <= imemData;
                            pcOut       <= pc;
                            pc          <= pc_seq;
                            state       <= S_REQ;
                        end else begin
                            buf_word <= imemData;
                            buf_pc   <= pc;
                            pc       <= pc_seq;
                            state    <= S_HOLD;
                        end
                    end else if (redirect) begin
                        squash <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        state <= S_REQ;
                    end else if (!stall) begin
                        instrValid  <= 1'b1;
                        instruction <= buf_word;
                        pcOut       <= buf_pc;
                        state       <= S_REQ;
                    end
                end

                S_HALT: state <= S_HALT;

                default: state <= S_IDLE;
            endcase

            if (take_redirect) begin
                pc         <= target;
                instrValid <= 1'b0;
            end

`ifdef FETCH_ALIGN_CHECK_EN
            if (take_redirect && bad_target) begin
                fetchFault <= 1'b1;
                squash     <= 1'b0;
                instrValid <= 1'b0;
                state      <= S_HALT;
            end
`endif
        end
    end

endmodule
